pc_sequencer: RTL and testbench

//  Parametrised fetch-PC register plus next-PC selection for the pipelined MIPS core.

---
 rtl/pc_sequencer.sv | 80 ++++++++
 tb/tb_pc_sequencer.sv | 106 ++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-PC register with prioritised next-PC selection and stall-time redirect buffering.
// Define PC_ALIGN_CHECK_EN to trap misaligned jr/eret targets to EXC_VEC (adel/bad_pc); otherwise targets are word-aligned.
module pc_sequencer #(
   parameter int          ADDR_W   = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              br_req,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_pc,
   input  logic [15:0]       imm16,
   input  logic              j_req,
   input  logic [25:0]       j_index,
   input  logic              jr_req,
   input  logic [ADDR_W-1:0] jr_target,
   input  logic              exc_req,
   input  logic              eret_req,
   input  logic [ADDR_W-1:0] epc,
   output logic [ADDR_W-1:0] pc,
   output logic              redirect,
   output logic              pend_valid,
   output logic              adel,
   output logic [ADDR_W-1:0] bad_pc
);
   localparam logic [ADDR_W-1:0] RST_V = RESET_PC[ADDR_W-1:0];
   localparam logic [ADDR_W-1:0] EXC_V = EXC_VEC[ADDR_W-1:0];
   localparam logic [ADDR_W-1:0] FOUR  = ADDR_W'(4);
   logic [ADDR_W-1:0] pc_q, pc_d, pend_tgt_q, pend_tgt_d, bad_pc_q, bad_pc_d;
   logic              redirect_q, redirect_d, pend_valid_q, pend_valid_d, adel_q, adel_d;
   logic [ADDR_W-1:0] link, br_tgt, j_tgt, id_tgt, ld_tgt;
   logic              id_req, urgent, load;
   always_comb begin
      link         = br_pc + FOUR;
      br_tgt       = link + {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};
      j_tgt        = {link[ADDR_W-1:28], j_index, 2'b00};
      id_req       = jr_req | j_req | (br_req & br_taken);
      id_tgt       = jr_req ? jr_target : j_req ? j_tgt : br_tgt;
      urgent       = exc_req | eret_req;
      // exc/eret bypass the stall; buffered targets only drain once the stall lifts
      load         = urgent | (!stall & (id_req | pend_valid_q));
      ld_tgt       = exc_req ? EXC_V : eret_req ? epc : id_req ? id_tgt : pend_tgt_q;
      redirect_d   = load;
      pend_valid_d = load ? 1'b0 : pend_valid_q | (stall & id_req);
      pend_tgt_d   = (!urgent & stall & id_req) ? id_tgt : pend_tgt_q;
`ifdef PC_ALIGN_CHECK_EN
      adel_d       = load & (ld_tgt[1:0] != 2'b00);
      bad_pc_d     = adel_d ? ld_tgt : bad_pc_q;
      pc_d         = adel_d ? EXC_V : load ? ld_tgt : stall ? pc_q : pc_q + FOUR;
`else
      adel_d       = 1'b0;
      bad_pc_d     = '0;
      pc_d         = load ? (ld_tgt & {{(ADDR_W-2){1'b1}}, 2'b00}) : stall ? pc_q : pc_q + FOUR;
`endif
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q         <= RST_V;
         redirect_q   <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_tgt_q   <= '0;
         adel_q       <= 1'b0;
         bad_pc_q     <= '0;
      end else begin
         pc_q         <= pc_d;
         redirect_q   <= redirect_d;
         pend_valid_q <= pend_valid_d;
         pend_tgt_q   <= pend_tgt_d;
         adel_q       <= adel_d;
         bad_pc_q     <= bad_pc_d;
      end
   end
   assign pc         = pc_q;
   assign redirect   = redirect_q;
   assign pend_valid = pend_valid_q;
   assign adel       = adel_q;
   assign bad_pc     = bad_pc_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed-vector bench for pc_sequencer; inputs driven and outputs sampled on the falling edge.
module tb_pc_sequencer;
   logic        clk = 1'b0, reset = 1'b1, stall = 1'b0;
   logic        br_req = 1'b0, br_taken = 1'b0, j_req = 1'b0, jr_req = 1'b0, exc_req = 1'b0, eret_req = 1'b0;
   logic [31:0] br_pc = '0, jr_target = '0, epc = '0;
   logic [15:0] imm16 = '0;
   logic [25:0] j_index = '0;
   logic [31:0] pc, bad_pc;
   logic        redirect, pend_valid, adel;
   int          checks = 0, failures = 0;
   pc_sequencer dut (
      .clk(clk), .reset(reset), .stall(stall), .br_req(br_req), .br_taken(br_taken), .br_pc(br_pc),
      .imm16(imm16), .j_req(j_req), .j_index(j_index), .jr_req(jr_req), .jr_target(jr_target),
      .exc_req(exc_req), .eret_req(eret_req), .epc(epc), .pc(pc), .redirect(redirect),
      .pend_valid(pend_valid), .adel(adel), .bad_pc(bad_pc)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask
   task automatic idle();
      stall = 0; br_req = 0; br_taken = 0; j_req = 0; jr_req = 0; exc_req = 0; eret_req = 0;
   endtask
   task automatic tick();
      @(negedge clk);
   endtask
   initial begin
      tick(); tick();
      reset = 0;
      check("rst_pc", pc, 32'h3000);
      check("rst_redir", {31'b0, redirect}, 0);
      check("rst_pend", {31'b0, pend_valid}, 0);
      check("rst_adel", {31'b0, adel}, 0);
      check("rst_badpc", bad_pc, 0);
      tick(); check("seq1", pc, 32'h3004);
      tick(); check("seq2", pc, 32'h3008);
      tick(); check("seq3", pc, 32'h300C); check("seq_redir", {31'b0, redirect}, 0);
      br_req = 1; br_taken = 1; br_pc = 32'h3004; imm16 = 16'hFFFE;
      tick(); check("br_pc", pc, 32'h3000); check("br_redir", {31'b0, redirect}, 1);
      idle();
      tick(); check("br_after", pc, 32'h3004); check("br_pulse", {31'b0, redirect}, 0);
      j_req = 1; br_pc = 32'h3010; j_index = 26'h0000C10;
      tick(); check("j_pc", pc, 32'h3040);
      idle(); br_req = 1; br_taken = 0;
      tick(); check("nt_pc", pc, 32'h3044); check("nt_redir", {31'b0, redirect}, 0);
      idle(); stall = 1; jr_req = 1; jr_target = 32'h3100;
      tick(); check("st1_pc", pc, 32'h3044); check("st1_pend", {31'b0, pend_valid}, 1);
      check("st1_redir", {31'b0, redirect}, 0);
      jr_req = 0;
      tick(); check("st2_pc", pc, 32'h3044);
      tick(); check("st3_pc", pc, 32'h3044); check("st3_pend", {31'b0, pend_valid}, 1);
      stall = 0;
      tick(); check("drain_pc", pc, 32'h3100); check("drain_pend", {31'b0, pend_valid}, 0);
      check("drain_redir", {31'b0, redirect}, 1);
      tick(); check("drain_seq", pc, 32'h3104);
      stall = 1; br_req = 1; br_taken = 1; br_pc = 32'h3104; imm16 = 16'h0010;
      tick(); check("ow1_pc", pc, 32'h3104);
      idle(); stall = 1; j_req = 1; br_pc = 32'h3104; j_index = 26'h0000C80;
      tick(); check("ow2_pc", pc, 32'h3104);
      idle();
      tick(); check("ow_pc", pc, 32'h3200);
      stall = 1; jr_req = 1; jr_target = 32'h3300;
      tick(); check("t5_pend", {31'b0, pend_valid}, 1);
      jr_req = 0; exc_req = 1;
      tick(); check("exc_pc", pc, 32'h4180); check("exc_pend", {31'b0, pend_valid}, 0);
      check("exc_redir", {31'b0, redirect}, 1);
      idle(); eret_req = 1; epc = 32'h3020; jr_req = 1; jr_target = 32'h3500;
      tick(); check("eret_pc", pc, 32'h3020);
      idle();
      tick(); check("eret_seq", pc, 32'h3024); check("eret_redir", {31'b0, redirect}, 0);
      exc_req = 1; jr_req = 1; jr_target = 32'h3500;
      tick(); check("prio_exc", pc, 32'h4180);
      idle(); jr_req = 1; jr_target = 32'h3400; j_req = 1; j_index = 26'h0000C80; br_req = 1; br_taken = 1;
      tick(); check("prio_jr", pc, 32'h3400);
      idle(); j_req = 1; br_pc = 32'h3000; j_index = 26'h0000C80; br_req = 1; br_taken = 1; imm16 = 16'h0004;
      tick(); check("prio_j", pc, 32'h3200);
      idle(); jr_req = 1; jr_target = 32'h3102;
      tick();
`ifdef PC_ALIGN_CHECK_EN
      check("mis_pc", pc, 32'h4180); check("mis_adel", {31'b0, adel}, 1); check("mis_bad", bad_pc, 32'h3102);
      idle();
      tick(); check("mis_adel_pulse", {31'b0, adel}, 0);
`else
      check("mis_pc", pc, 32'h3100); check("mis_adel", {31'b0, adel}, 0); check("mis_bad", bad_pc, 0);
      idle();
      tick();
`endif
      jr_req = 1; jr_target = 32'hFFFF_FFFC;
      tick(); check("wrap_top", pc, 32'hFFFF_FFFC);
      idle();
      tick(); check("wrap_zero", pc, 32'h0);
      stall = 1; jr_req = 1; jr_target = 32'h3600;
      tick(); check("mr_pend", {31'b0, pend_valid}, 1);
      #2 reset = 1;
      #1 check("mr_pc", pc, 32'h3000); check("mr_pend0", {31'b0, pend_valid}, 0);
      idle();
      tick(); reset = 0;
      tick(); check("mr_drop", pc, 32'h3004); check("mr_redir", {31'b0, redirect}, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
